meta_disposition: RTL

Downstream neighbour of the metadata-modification ALU in each RMT stage. It consumes the combined metadata+compare word that the ALU produces, drops entries whose discard flag is set, and buffers the survivors in a small FIFO. It presents them to the next consumer (the next stage's key extractor or the deparser) over a valid/ready handshake. The upstream ALU has no backpressure, so this block absorbs bursts and accounts for every entry it has to drop.

---
 rtl/rmt_meta_pkg.sv | 17 +
 rtl/meta_sync_fifo.sv | 50 +++++
 rtl/meta_disposition.sv | 95 +++++++++
 3 files changed

// File: rtl/rmt_meta_pkg.sv
// Shared RMT metadata definitions: fixed field positions inside the combined
// metadata+compare word and the word type itself.
package rmt_meta_pkg;

  localparam int unsigned META_LEN_DEF = 256;
  localparam int unsigned COMP_LEN_DEF = 100;
  localparam int unsigned META_WORD_W  = META_LEN_DEF + COMP_LEN_DEF;

  localparam int unsigned META_DISCARD_BIT = 128;
  localparam int unsigned META_DSTPORT_HI  = 31;
  localparam int unsigned META_DSTPORT_LO  = 24;
  localparam int unsigned META_NTID_HI     = 355;
  localparam int unsigned META_NTID_LO     = 350;

  typedef logic [META_WORD_W-1:0] meta_word_t;

endpackage

// File: rtl/meta_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// The read port shows zero while empty so the head is clean out of reset.
module meta_sync_fifo #(
  parameter int unsigned WIDTH = 356,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/meta_disposition.sv
// Captures ALU metadata words, drops flagged entries and buffers survivors
// for a valid/ready consumer. Optional statistics: META_DISP_STATS_EN.
module meta_disposition
  import rmt_meta_pkg::*;
#(
  parameter int unsigned META_LEN = 256,
  parameter int unsigned COMP_LEN = 100,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
  input  logic                         comp_meta_data_valid_in,
  output logic [META_LEN+COMP_LEN-1:0] meta_data_out,
  output logic                         meta_valid_out,
  input  logic                         meta_ready_in,
  output logic [$clog2(DEPTH):0]       fifo_level
`ifdef META_DISP_STATS_EN
  ,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             ovf_cnt,
  input  logic                         stat_clr
`endif
);

  localparam int unsigned W = META_LEN + COMP_LEN;

  logic [W-1:0] cap_data;
  logic         cap_vld;
  logic         discard;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= comp_meta_data_valid_in;
    end
  end

  always_ff @(posedge clk) begin
    cap_data <= comp_meta_data_in;
  end

  assign discard        = cap_data[META_DISCARD_BIT];
  assign meta_valid_out = ~fifo_empty;
  assign pop            = meta_valid_out & meta_ready_in;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push           = cap_vld & ~discard & (~fifo_full | pop);

  meta_sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (cap_data),
    .pop     (pop),
    .rd_data (meta_data_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

`ifdef META_DISP_STATS_EN
  logic drop_inc;
  logic ovf_inc;

  assign drop_inc = cap_vld & discard;
  assign ovf_inc  = cap_vld & ~discard & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (stat_clr) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (drop_inc) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (ovf_inc) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
